// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - per-requester RAM access bundle between a master and the arbiter
//
// Purpose: groups one requester's request/grant handshake and read-return
//          signals so the arbiter can take each master as a single port.
// Signals:
//   req    master -> arbiter  transaction requested this cycle
//   we     master -> arbiter  1 = write, 0 = read
//   lock   master -> arbiter  ask to keep ownership for the following cycle
//   addr   master -> arbiter  word address
//   wdata  master -> arbiter  write data
//   gnt    arbiter -> master  request accepted this cycle (combinational)
//   rvalid arbiter -> master  read data valid on rdata (registered)
//   rdata  arbiter -> master  read data (shared RAM output)
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter with bounded lock sharing one single-port sync RAM
//
// Purpose: grants one of two masters per cycle onto the RAM port, round-robin
//          on contention, with an optional lock that is forcibly released
//          after LOCK_MAX consecutive grants when the other master waits.
//          Read validity is returned to the issuing master one cycle later.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   m0, m1    ram_arbiter_if.slave  requester ports (master 0 wins first tie)
//   ram_addr  out  RAM word address
//   ram_din   out  RAM write data
//   ram_re    out  RAM read enable
//   ram_we    out  RAM write enable
//   ram_dout  in   RAM read data, valid the cycle after ram_re
module ram_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          m0,
    ram_arbiter_if.slave          m1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_re,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [3:0] LP_LOCK_MAX = 4'(LOCK_MAX);

    logic       r_lock_valid;
    logic       r_lock_owner;
    logic [3:0] r_lock_cnt;
    logic       r_last;       // most recent winner; reset to 1 so master 0 wins the first tie
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_any;
    logic       w_win;
    logic       w_owner_req;
    logic       w_other_req;
    logic       w_lock_valid_nxt;
    logic       w_lock_owner_nxt;
    logic [3:0] w_lock_cnt_nxt;
    logic       w_last_nxt;

    // Grant selection and next-state computation
    always_comb begin
        w_gnt0           = 1'b0;
        w_gnt1           = 1'b0;
        w_owner_req      = r_lock_owner ? m1.req : m0.req;
        w_other_req      = r_lock_owner ? m0.req : m1.req;
        w_lock_valid_nxt = 1'b0;
        w_lock_owner_nxt = 1'b0;
        w_lock_cnt_nxt   = 4'd0;
        w_last_nxt       = r_last;

        if (r_lock_valid && w_owner_req && ((r_lock_cnt < LP_LOCK_MAX) || !w_other_req)) begin
            w_gnt0 = !r_lock_owner;
            w_gnt1 = r_lock_owner;
        end else if (m0.req && !m1.req) begin
            w_gnt0 = 1'b1;
        end else if (m1.req && !m0.req) begin
            w_gnt1 = 1'b1;
        end else if (m0.req && m1.req) begin
            // An exhausted lock owner was the last winner, so this also forces release
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
        end

        // Nothing is granted while reset is held
        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        w_any = w_gnt0 | w_gnt1;
        w_win = w_gnt1;

        if (w_any) begin
            w_last_nxt = w_win;
            if (w_win ? m1.lock : m0.lock) begin
                w_lock_valid_nxt = 1'b1;
                w_lock_owner_nxt = w_win;
                if (r_lock_valid && (r_lock_owner == w_win))
                    // Saturate so a long uncontested lock cannot wrap and regain extra grants
                    w_lock_cnt_nxt = (r_lock_cnt >= LP_LOCK_MAX) ? r_lock_cnt : r_lock_cnt + 4'd1;
                else
                    w_lock_cnt_nxt = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
            r_lock_cnt   <= 4'd0;
            r_last       <= 1'b1;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_lock_valid <= w_lock_valid_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_last       <= w_last_nxt;
            r_rvalid0    <= w_gnt0 && !m0.we;
            r_rvalid1    <= w_gnt1 && !m1.we;
        end
    end

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = ram_dout;
    assign m1.rdata  = ram_dout;

    assign ram_addr = w_gnt1 ? m1.addr  : m0.addr;
    assign ram_din  = w_gnt1 ? m1.wdata : m0.wdata;
    assign ram_we   = (w_gnt0 && m0.we)  || (w_gnt1 && m1.we);
    assign ram_re   = (w_gnt0 && !m0.we) || (w_gnt1 && !m1.we);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking scoreboard bench for ram_arbiter
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_dout;

    ram_arbiter_if #(.ADDR_WIDTH(30), .DATA_WIDTH(32)) m0_if ();
    ram_arbiter_if #(.ADDR_WIDTH(30), .DATA_WIDTH(32)) m1_if ();

    ram_arbiter #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .LOCK_MAX(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_re   (ram_re),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model seen by the DUT and a separate reference image for expectations
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr[7:0]];
    end

    typedef struct {
        bit          mst;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rv_cnt0  = 0;
    int   rv_cnt1  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock cycle: compare at the falling edge, then advance past the rising edge
    task automatic step(input bit e_g0, input bit e_g1, input string tag);
        exp_t        e;
        logic        wwe;
        logic [29:0] waddr;
        logic [31:0] wdata;
        @(negedge clk);
        if (m0_if.rvalid === 1'b1) rv_cnt0++;
        if (m1_if.rvalid === 1'b1) rv_cnt1++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rv0"}, 32'(m0_if.rvalid), 32'(e.mst == 1'b0));
            check({tag, "_rv1"}, 32'(m1_if.rvalid), 32'(e.mst == 1'b1));
            check({tag, "_rdata"}, e.mst ? m1_if.rdata : m0_if.rdata, e.data);
        end else begin
            check({tag, "_rv0_idle"}, 32'(m0_if.rvalid), 32'd0);
            check({tag, "_rv1_idle"}, 32'(m1_if.rvalid), 32'd0);
        end
        check({tag, "_gnt0"}, 32'(m0_if.gnt), 32'(e_g0));
        check({tag, "_gnt1"}, 32'(m1_if.gnt), 32'(e_g1));
        if (e_g0 || e_g1) begin
            wwe   = e_g1 ? m1_if.we    : m0_if.we;
            waddr = e_g1 ? m1_if.addr  : m0_if.addr;
            wdata = e_g1 ? m1_if.wdata : m0_if.wdata;
            check({tag, "_ram_we"}, 32'(ram_we), 32'(wwe));
            check({tag, "_ram_re"}, 32'(ram_re), 32'(!wwe));
            check({tag, "_ram_addr"}, 32'(ram_addr), 32'(waddr));
            if (wwe) begin
                check({tag, "_ram_din"}, ram_din, wdata);
                ref_mem[waddr[7:0]] = wdata;
            end else begin
                e.mst  = e_g1;
                e.data = ref_mem[waddr[7:0]];
                exp_q.push_back(e);
            end
        end else begin
            check({tag, "_ram_we_idle"}, 32'(ram_we), 32'd0);
            check({tag, "_ram_re_idle"}, 32'(ram_re), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit mst, input bit req, input bit we, input bit lock,
                         input logic [29:0] addr, input logic [31:0] wdata);
        if (mst) begin
            m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        mem[8'h10]     = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);

        // Reset mid-cycle, then requests held during reset must not be granted
        #2 rst = 1'b1;
        #1;
        check("rst_rv0", 32'(m0_if.rvalid), 32'd0);
        check("rst_rv1", 32'(m1_if.rvalid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'd1, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 30'd2, 32'd0);
        #1;
        check("rst_gnt0", 32'(m0_if.gnt), 32'd0);
        check("rst_gnt1", 32'(m1_if.gnt), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        step(1'b0, 1'b0, "idle_a");
        step(1'b0, 1'b0, "idle_b");

        // Single master read
        drive(1'b1, 1'b1, 1'b0, 1'b0, 30'h10, 32'd0);
        step(1'b0, 1'b1, "single_rd");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "single_ret");

        // Round-robin contention; last winner is master 1 so master 0 starts
        rv_cnt0 = 0;
        rv_cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 30'(8'h20 + i), 32'd0);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 30'(8'h40 + i), 32'd0);
            step((i % 2) == 0, (i % 2) == 1, $sformatf("rr%0d", i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "rr_tail");
        check("rr_rv_count0", 32'(rv_cnt0), 32'd3);
        check("rr_rv_count1", 32'(rv_cnt1), 32'd3);

        // Lock bounded by LOCK_MAX=4 while master 0 waits
        drive(1'b1, 1'b1, 1'b0, 1'b1, 30'h50, 32'd0);
        step(1'b0, 1'b1, "lock1");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h60, 32'd0);
        step(1'b0, 1'b1, "lock2");
        step(1'b0, 1'b1, "lock3");
        step(1'b0, 1'b1, "lock4");
        step(1'b1, 1'b0, "lock_forced");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b1, "lock_back");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "lock_tail");

        // Uncontested lock keeps the port indefinitely
        drive(1'b1, 1'b1, 1'b0, 1'b1, 30'h51, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, $sformatf("lock_long%0d", i));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "lock_long_tail");

        // Write by master 0 then read back by master 1
        drive(1'b0, 1'b1, 1'b1, 1'b0, 30'd5, 32'h1234_5678);
        step(1'b1, 1'b0, "wr");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 30'd5, 32'd0);
        step(1'b0, 1'b1, "wr_rd");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "wr_ret");
        check("wr_data_seen", ref_mem[5], 32'h1234_5678);

        // Reset between a read grant and its return kills the rvalid
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h10, 32'd0);
        step(1'b1, 1'b0, "rstrd");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        rst = 1'b1;
        #1;
        check("rstrd_rv0", 32'(m0_if.rvalid), 32'd0);
        check("rstrd_rv1", 32'(m1_if.rvalid), 32'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        step(1'b0, 1'b0, "rstrd_idle");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h21, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 30'h41, 32'd0);
        step(1'b1, 1'b0, "post_rst_rr0");
        step(1'b0, 1'b1, "post_rst_rr1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b0, 1'b0, "post_rst_tail");
        step(1'b0, 1'b0, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
